// File: rtl/sigmadelta_pkg.sv
// sigmadelta_pkg: shared CIC order, width helper and left-align/saturate scaling for the delta-sigma paths.
// SIGMADELTA_ADC_SINC3_EN selects a third-order CIC instead of second-order.
package sigmadelta_pkg;
`ifdef SIGMADELTA_ADC_SINC3_EN
  localparam int CIC_N = 3;
`else
  localparam int CIC_N = 2;
`endif
  function automatic int cic_k(input int dlog2);
    return CIC_N * dlog2;
  endfunction
  // Full-scale c = 2^k cannot be represented in k bits, so clamp before aligning.
  function automatic logic [31:0] left_align(input logic [31:0] c, input int k, input int sw);
    logic [31:0] lim;
    logic [31:0] cs;
    lim = (32'd1 << k) - 32'd1;
    cs = (c > lim) ? lim : c;
    return (k <= sw) ? cs << (sw - k) : cs >> (k - sw);
  endfunction
endpackage

// File: rtl/sigmadelta_cic_integrator.sv
// sigmadelta_cic_integrator: one free-running modulo accumulator stage of the CIC filter.
module sigmadelta_cic_integrator #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_acc
);
  logic [W-1:0] r_acc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_acc <= '0;
    else r_acc <= r_acc + i_d;
  assign o_acc = r_acc;
endmodule

// File: rtl/sigmadelta_adc_decimator.sv
// sigmadelta_adc_decimator: first-order delta-sigma loop around an external comparator plus CIC decimator to unsigned PCM.
// SIGMADELTA_ADC_SINC3_EN (via sigmadelta_pkg) raises the CIC order from 2 to 3.
module sigmadelta_adc_decimator
  import sigmadelta_pkg::*;
#(
  parameter int signalwidth = 16,
  parameter int decimlog2 = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmp_in,
  output logic                   fb,
  output logic [signalwidth-1:0] q,
  output logic                   q_valid
);
  localparam int K = cic_k(decimlog2);
  localparam int KW = K + 1;
  localparam logic [1:0] SETTLE = 2'(CIC_N);
  logic                 r_s1;
  logic                 r_s2;
  logic [decimlog2-1:0] r_cnt;
  logic [1:0]           r_settle;
  logic [KW-1:0]        r_dly [CIC_N];
  logic [KW-1:0]        w_int [CIC_N+1];
  logic [KW-1:0]        w_comb [CIC_N+1];
  logic                 w_tick;
  assign w_tick = &r_cnt;
  assign w_int[0] = KW'(fb);
  assign w_comb[0] = w_int[CIC_N];
  for (genvar g = 0; g < CIC_N; g++) begin : g_stage
    sigmadelta_cic_integrator #(.W(KW)) u_int (
      .clk    (clk),
      .reset_n(reset_n),
      .i_d    (w_int[g]),
      .o_acc  (w_int[g+1])
    );
    assign w_comb[g+1] = w_comb[g] - r_dly[g];
  end
  // fb is the loop bit and also the filter input, so the filter sees exactly what drives the RC.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      fb       <= 1'b0;
      r_cnt    <= '0;
      r_settle <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      for (int i = 0; i < CIC_N; i++) r_dly[i] <= '0;
    end else begin
      r_s1    <= cmp_in;
      r_s2    <= r_s1;
      fb      <= r_s2;
      r_cnt   <= r_cnt + 1'b1;
      q_valid <= w_tick && (r_settle == SETTLE);
      if (w_tick) begin
        for (int i = 0; i < CIC_N; i++) r_dly[i] <= w_comb[i];
        if (r_settle == SETTLE) q <= signalwidth'(left_align(32'(w_comb[CIC_N]), K, signalwidth));
        else r_settle <= r_settle + 1'b1;
      end
    end
endmodule

// File: doc/sigmadelta_adc_decimator.md
Name: sigmadelta_adc_decimator

Overview:
- Receive side of the delta-sigma path. Closes a first-order delta-sigma ADC loop around an external comparator and RC network.
- Decimates the resulting 1-bit stream with a CIC (sinc) filter into unsigned PCM samples.
- Output sample format matches the DAC input format, so the ADC's PCM can be looped straight back to the DAC.
- Sits between the comparator input pin and the audio/sample consumer.

Parameters:
- signalwidth, 16, width of PCM output sample (unsigned)
- decimlog2, 5, log2 of decimation ratio (default 32 clocks per sample, equal to the DAC PWM frame)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cmp_in  input  1  comparator output from pin; asynchronous to clk
- fb  output  1  feedback bit to pin; drives the RC integrator
- q  output  signalwidth  unsigned PCM sample, held between strobes
- q_valid  output  1  one-clock strobe when q updates

Behaviour:
- Reset/clock: one clock `clk`; reset is asynchronous, active-low on `reset_n`. Reset clears every register: sync flops, fb=0, integrators, comb delays, counters, q=0, q_valid=0.
- Input sync and loop bit:
  - cmp_in passes through a 2-flop synchroniser to give s.
  - fb <= s each clock, so fb lags cmp_in by 3 clocks.
  - The bitstream bit used by the filter is x = fb.
- CIC order: N=2 by default. N=3 when the optional macro is defined. Let K = N*decimlog2.
- Integrators:
  - N cascaded unsigned accumulators, each K+1 bits wide.
  - All update every clock: i1 += x, then ik += i(k-1), using registered previous-stage values.
  - Modular wrap-around is intended and correct; there is no saturation in the integrators.
- Decimation counter:
  - decimlog2 bits, increments every clock and wraps.
  - On the clock where the counter is all ones (the "tick"), the last integrator is sampled into the comb stage.
- Comb stage:
  - N cascaded differences, each with a one-sample delay register, all K+1 bits, modulo arithmetic.
  - Result c is in the range 0..2^K.
  - Runs once per tick.
- Output scaling:
  - cs = min(c, 2^K-1).
  - q = cs left-aligned into signalwidth: shift left by (signalwidth-K) if K<=signalwidth, otherwise shift right by (K-signalwidth), truncating.
- Timing: q and q_valid register one clock after the tick. q_valid is high for exactly that clock. q holds its value otherwise.
- Settling:
  - A 2-bit settle counter suppresses q_valid (and q update) for the first N ticks after reset.
  - The first valid sample is at tick N+1.
  - After that, strobe period is exactly 2^decimlog2 clocks.
- Reset mid-frame: all state restarts as from power-up; the settle sequence repeats and no partial sample is emitted.
- No back-pressure: the consumer must take q within 2^decimlog2 clocks.

Optional Feature:
- Macro: SIGMADELTA_ADC_SINC3_EN.
- Defined: N=3. Three integrators and three combs; settle suppresses 3 ticks; K=3*decimlog2.
- Undefined: N=2 as above.
- Port list is identical in both builds.

Decomposition:
- Shared package (sigmadelta_pkg): CIC order constant (selected by the macro), K width function, and the left-align/saturate helper used by both the ADC and future DAC test paths.
- Natural sub-module: sigmadelta_cic_integrator (one accumulator stage, parameterised width), instantiated N times.
- Comb stage stays inline.

Test Plan (signalwidth=16, decimlog2=5):
- cmp_in held 1 from reset -> fb=1 from clock 3. After settle, every strobe gives q=16'hFFC0 (c=1024 saturated to 1023, <<6). Strobes are 32 clocks apart.
- cmp_in held 0 -> q_valid strobes every 32 clocks, q=16'h0000.
- cmp_in alternating 1,0 each clock -> q=16'h8000 (c=512) on every valid strobe.
- Count strobes after reset release -> first q_valid follows the 3rd tick (N=2), no earlier strobe. Strobe width is exactly 1 clock.
- Assert reset_n low mid-frame (counter=17) with cmp_in=1 -> q=0, q_valid=0, fb=0 immediately (asynchronous). After release, first strobe follows again after 3 ticks with q=16'hFFC0.
- With SIGMADELTA_ADC_SINC3_EN -> all-ones gives q=16'hFFFE (32768 saturated to 32767, <<1), alternating gives 16'h8000, and the first strobe follows the 4th tick.
